// File: rtl/opc_mem_arbiter_if.sv
// Bus bundle between the OPC memory arbiter and the CPU core, the host
// loader/debug port and the external memory pins. The arbiter uses the slave
// modport; whoever drives the requests and models the memory uses master.
interface opc_mem_arbiter_if;
    // CPU side
    logic        cpu_run;
    logic [10:0] cpu_addr;
    logic        cpu_rnw;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ce;
    // Host side
    logic        host_req;
    logic        host_rnw;
    logic [10:0] host_addr;
    logic [7:0]  host_wdata;
    logic [7:0]  host_rdata;
    logic        host_ack;
    // Status and debug (dbg_state mirrors the sequencer state encoding)
    logic        busy;
    logic [2:0]  dbg_state;
    // External memory pins
    logic [7:0]  mem_a;
    logic        mem_ale;
    logic [7:0]  mem_d_in;
    logic [7:0]  mem_d_out;
    logic        mem_d_oe;
    logic        mem_oe_n;
    logic        mem_we_n;

    // Requesters are level signals sampled only while the arbiter is idle;
    // completion is reported by a single-cycle cpu_ce / host_ack pulse.
    modport slave (
        input  cpu_run, cpu_addr, cpu_rnw, cpu_wdata,
        input  host_req, host_rnw, host_addr, host_wdata,
        input  mem_d_in,
        output cpu_rdata, cpu_ce, host_rdata, host_ack,
        output busy, dbg_state,
        output mem_a, mem_ale, mem_d_out, mem_d_oe, mem_oe_n, mem_we_n
    );

    modport master (
        output cpu_run, cpu_addr, cpu_rnw, cpu_wdata,
        output host_req, host_rnw, host_addr, host_wdata,
        output mem_d_in,
        input  cpu_rdata, cpu_ce, host_rdata, host_ack,
        input  busy, dbg_state,
        input  mem_a, mem_ale, mem_d_out, mem_d_oe, mem_oe_n, mem_we_n
    );
endinterface

// File: rtl/opc_mem_arbiter.sv
// OPC external memory arbiter. Shares the single 8-bit memory bus between the
// CPU core and the host port. Each transaction runs IDLE -> AHI (high address
// onto the pins with ALE) -> ALO (low address, strobes set up) -> DAT held for
// 1+WAIT_CYCLES cycles -> DONE (ce/ack pulse) -> IDLE. Ties alternate owners.
module opc_mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    opc_mem_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AHI  = 3'd1,
        ST_ALO  = 3'd2,
        ST_DAT  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic       OWN_CPU  = 1'b0;
    localparam logic       OWN_HOST = 1'b1;
    localparam logic [2:0] LP_WAIT  = 3'(WAIT_CYCLES);

    state_t      r_state;
    logic        r_owner;
    logic        r_last_owner;
    logic        r_rnw;
    logic [10:0] r_addr;
    logic [7:0]  r_wdata;
    logic [2:0]  r_wait;
    logic [7:0]  r_cpu_rdata;
    logic [7:0]  r_host_rdata;
    logic        r_cpu_ce;
    logic        r_host_ack;
    logic [7:0]  r_mem_a;
    logic        r_mem_ale;
    logic [7:0]  r_mem_d_out;
    logic        r_mem_d_oe;
    logic        r_mem_oe_n;
    logic        r_mem_we_n;

    logic        w_grant_any;
    logic        w_grant_host;
    logic        w_sel_rnw;
    logic [10:0] w_sel_addr;
    logic [7:0]  w_sel_wdata;

    // Arbitration: a lone requester wins; on a tie the one not served last wins
    always_comb begin
        w_grant_any  = bus.cpu_run | bus.host_req;
        w_grant_host = bus.host_req & (~bus.cpu_run | (r_last_owner == OWN_CPU));
        w_sel_rnw    = w_grant_host ? bus.host_rnw   : bus.cpu_rnw;
        w_sel_addr   = w_grant_host ? bus.host_addr  : bus.cpu_addr;
        w_sel_wdata  = w_grant_host ? bus.host_wdata : bus.cpu_wdata;
    end

    // Transaction sequencer: one state per bus phase, every pin output registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_CPU;
            r_last_owner <= OWN_HOST;
            r_rnw        <= 1'b1;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wait       <= '0;
            r_cpu_rdata  <= '0;
            r_host_rdata <= '0;
            r_cpu_ce     <= 1'b0;
            r_host_ack   <= 1'b0;
            r_mem_a      <= '0;
            r_mem_ale    <= 1'b0;
            r_mem_d_out  <= '0;
            r_mem_d_oe   <= 1'b0;
            r_mem_oe_n   <= 1'b1;
            r_mem_we_n   <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Latch the whole request so the requester may change or drop it
                    if (w_grant_any) begin
                        r_state   <= ST_AHI;
                        r_owner   <= w_grant_host ? OWN_HOST : OWN_CPU;
                        r_rnw     <= w_sel_rnw;
                        r_addr    <= w_sel_addr;
                        r_wdata   <= w_sel_wdata;
                        r_mem_a   <= {5'b0, w_sel_addr[10:8]};
                        r_mem_ale <= 1'b1;
                    end
                end
                ST_AHI: begin
                    r_state   <= ST_ALO;
                    r_mem_a   <= r_addr[7:0];
                    r_mem_ale <= 1'b0;
                    if (r_rnw) begin
                        r_mem_oe_n <= 1'b0;
                    end else begin
                        r_mem_d_oe  <= 1'b1;
                        r_mem_d_out <= r_wdata;
                    end
                end
                ST_ALO: begin
                    // Write strobe only opens once address and data have settled
                    r_state <= ST_DAT;
                    r_wait  <= LP_WAIT;
                    if (!r_rnw) begin
                        r_mem_we_n <= 1'b0;
                    end
                end
                ST_DAT: begin
                    if (r_wait == 3'd0) begin
                        r_state      <= ST_DONE;
                        r_mem_oe_n   <= 1'b1;
                        r_mem_we_n   <= 1'b1;
                        r_mem_d_oe   <= 1'b0;
                        r_last_owner <= r_owner;
                        if (r_owner == OWN_HOST) begin
                            r_host_ack <= 1'b1;
                            if (r_rnw) begin
                                r_host_rdata <= bus.mem_d_in;
                            end
                        end else begin
                            r_cpu_ce <= 1'b1;
                            if (r_rnw) begin
                                r_cpu_rdata <= bus.mem_d_in;
                            end
                        end
                    end else begin
                        r_wait <= r_wait - 3'd1;
                    end
                end
                ST_DONE: begin
                    r_state    <= ST_IDLE;
                    r_cpu_ce   <= 1'b0;
                    r_host_ack <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_rdata  = r_cpu_rdata;
    assign bus.cpu_ce     = r_cpu_ce;
    assign bus.host_rdata = r_host_rdata;
    assign bus.host_ack   = r_host_ack;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.dbg_state  = r_state;
    assign bus.mem_a      = r_mem_a;
    assign bus.mem_ale    = r_mem_ale;
    assign bus.mem_d_out  = r_mem_d_out;
    assign bus.mem_d_oe   = r_mem_d_oe;
    assign bus.mem_oe_n   = r_mem_oe_n;
    assign bus.mem_we_n   = r_mem_we_n;

endmodule

// File: tb/tb_opc_mem_arbiter.sv
// Bench for opc_mem_arbiter: an external SRAM with a high-address latch, a
// transaction-level reference model, directed scenarios and a random phase.
// A second instance with WAIT_CYCLES=3 covers the slow-memory timing.
module tb_opc_mem_arbiter;

  localparam int W0 = 0;

  logic clk;
  logic rst_n;

  opc_mem_arbiter_if bus();
  opc_mem_arbiter_if bus3();

  opc_mem_arbiter #(.WAIT_CYCLES(0)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  opc_mem_arbiter #(.WAIT_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- external SRAM with ALE-latched high address ----------------
  logic [7:0]  sram [0:2047];
  logic [2:0]  sram_hi;
  logic        pre_we;
  logic [10:0] pre_addr;
  logic [7:0]  pre_data;

  always @(posedge clk) begin
    if (bus.mem_ale) sram_hi <= bus.mem_a[2:0];
    if (pre_we) sram[pre_addr] <= pre_data;
    else if (!bus.mem_we_n) sram[{sram_hi, bus.mem_a}] <= bus.mem_d_out;
  end

  assign bus.mem_d_in  = bus.mem_oe_n ? 8'h5A : sram[{sram_hi, bus.mem_a}];
  assign bus3.mem_d_in = 8'h00;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int ack_q[$];
  int ce_q[$];
  int ce3_q[$];
  int we_cnt = 0;
  logic [7:0] we_data = 8'h00;
  int we3_cnt = 0;
  int we3_first = -1;
  int we3_last = -1;

  // ---------------- reference model (transaction level) ----------------
  logic [7:0]  m_mem [0:2047];
  bit          m_act;
  int          m_g;
  bit          m_host;
  bit          m_rnw;
  logic [10:0] m_addr;
  logic [7:0]  m_wdata;
  bit          m_last_host;
  logic [7:0]  m_cpu_rd;
  logic [7:0]  m_host_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected pins for the current cycle, from its offset k since the grant:
  // k=1 high address, k=2 low address, k=3..3+W data, k=4+W completion.
  task automatic model_check();
    int   k;
    logic e_busy, e_ale, e_oe_n, e_we_n, e_d_oe, e_ce, e_ack;
    e_busy = 1'b0; e_ale = 1'b0; e_oe_n = 1'b1; e_we_n = 1'b1;
    e_d_oe = 1'b0; e_ce = 1'b0; e_ack = 1'b0;
    if (m_act && cyc > m_g + 4 + W0) m_act = 1'b0;
    if (m_act) begin
      k = cyc - m_g;
      e_busy = 1'b1;
      if (k == 1) begin
        e_ale = 1'b1;
        check("ahi_mem_a", bus.mem_a, {5'b0, m_addr[10:8]});
      end else if (k <= 3 + W0) begin
        check("alo_mem_a", bus.mem_a, m_addr[7:0]);
        e_oe_n = ~m_rnw;
        e_d_oe = ~m_rnw;
        if (!m_rnw) check("wr_d_out", bus.mem_d_out, m_wdata);
        if (k >= 3) e_we_n = m_rnw;
      end else begin
        if (m_host) begin
          e_ack = 1'b1;
          if (m_rnw) m_host_rd = m_mem[m_addr];
        end else begin
          e_ce = 1'b1;
          if (m_rnw) m_cpu_rd = m_mem[m_addr];
        end
        if (!m_rnw) m_mem[m_addr] = m_wdata;
      end
    end
    check("busy", bus.busy, e_busy);
    check("mem_ale", bus.mem_ale, e_ale);
    check("mem_oe_n", bus.mem_oe_n, e_oe_n);
    check("mem_we_n", bus.mem_we_n, e_we_n);
    check("mem_d_oe", bus.mem_d_oe, e_d_oe);
    check("cpu_ce", bus.cpu_ce, e_ce);
    check("host_ack", bus.host_ack, e_ack);
    check("cpu_rdata", bus.cpu_rdata, m_cpu_rd);
    check("host_rdata", bus.host_rdata, m_host_rd);
  endtask

  // Arbitration for the current cycle, using the inputs just driven
  task automatic model_decide();
    if (!m_act && (bus.cpu_run || bus.host_req)) begin
      m_host = bus.host_req && (!bus.cpu_run || !m_last_host);
      m_act  = 1'b1;
      m_g    = cyc;
      m_rnw   = m_host ? bus.host_rnw   : bus.cpu_rnw;
      m_addr  = m_host ? bus.host_addr  : bus.cpu_addr;
      m_wdata = m_host ? bus.host_wdata : bus.cpu_wdata;
      m_last_host = m_host;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input bit cr, input bit crnw, input logic [10:0] ca, input logic [7:0] cd,
                        input bit hr, input bit hrnw, input logic [10:0] ha, input logic [7:0] hd);
    bus.cpu_run = cr;  bus.cpu_rnw = crnw;  bus.cpu_addr = ca;  bus.cpu_wdata = cd;
    bus.host_req = hr; bus.host_rnw = hrnw; bus.host_addr = ha; bus.host_wdata = hd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
    model_check();
    if (bus.host_ack) ack_q.push_back(cyc);
    if (bus.cpu_ce) ce_q.push_back(cyc);
    if (!bus.mem_we_n) begin
      we_cnt++;
      we_data = bus.mem_d_out;
    end
    if (!bus3.mem_we_n) begin
      we3_cnt++;
      if (we3_first < 0) we3_first = cyc;
      we3_last = cyc;
      check("w3_mem_a", bus3.mem_a, 8'h55);
      check("w3_d_out", bus3.mem_d_out, 8'hFF);
    end
    if (bus3.cpu_ce) ce3_q.push_back(cyc);
  endtask

  task automatic tick(input bit cr, input bit crnw, input logic [10:0] ca, input logic [7:0] cd,
                      input bit hr, input bit hrnw, input logic [10:0] ha, input logic [7:0] hd);
    next_cycle();
    set_in(cr, crnw, ca, cd, hr, hrnw, ha, hd);
    model_decide();
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 11'h0, 8'h0, 1'b0, 1'b1, 11'h0, 8'h0);
  endtask

  // Asserts reset at once (works mid-transaction), checks the async reset
  // values, releases on a falling edge; the cycle after release is cycle 1.
  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_state", bus.dbg_state, 3'd0);
    check("rst_mem_a", bus.mem_a, 8'h00);
    check("rst_ale", bus.mem_ale, 1'b0);
    check("rst_oe_n", bus.mem_oe_n, 1'b1);
    check("rst_we_n", bus.mem_we_n, 1'b1);
    check("rst_d_oe", bus.mem_d_oe, 1'b0);
    check("rst_d_out", bus.mem_d_out, 8'h00);
    check("rst_cpu_rdata", bus.cpu_rdata, 8'h00);
    check("rst_host_rdata", bus.host_rdata, 8'h00);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_cpu_ce", bus.cpu_ce, 1'b0);
      check("rst_host_ack", bus.host_ack, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_act = 1'b0;
    m_last_host = 1'b1;
    m_cpu_rd = 8'h00;
    m_host_rd = 8'h00;
    cyc = 1;
    model_check();
    model_decide();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] v;
    rst_n = 1'b1;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    set_in(1'b0, 1'b1, 11'h0, 8'h0, 1'b0, 1'b1, 11'h0, 8'h0);
    bus3.cpu_run = 1'b0; bus3.cpu_rnw = 1'b1; bus3.cpu_addr = 11'h0; bus3.cpu_wdata = 8'h0;
    bus3.host_req = 1'b0; bus3.host_rnw = 1'b1; bus3.host_addr = 11'h0; bus3.host_wdata = 8'h0;
    #2;
    rst_n = 1'b0;

    // Preload SRAM and model memory with identical random contents
    for (int i = 0; i < 2048; i++) begin
      v = (i == 11'h100) ? 8'hA5 : 8'($urandom);
      pre_we = 1'b1; pre_addr = 11'(i); pre_data = v;
      m_mem[i] = v;
      @(negedge clk);
    end
    pre_we = 1'b0;

    // CPU read of 0x100 from reset; WAIT=3 instance does a CPU write alongside
    bus3.cpu_run = 1'b1; bus3.cpu_rnw = 1'b0; bus3.cpu_addr = 11'h055; bus3.cpu_wdata = 8'hFF;
    set_in(1'b1, 1'b1, 11'h100, 8'h00, 1'b0, 1'b1, 11'h0, 8'h0);
    reset_dut();
    tick(1'b1, 1'b1, 11'h100, 8'h00, 1'b0, 1'b1, 11'h0, 8'h0);
    bus3.cpu_run = 1'b0;
    tick(1'b1, 1'b1, 11'h100, 8'h00, 1'b0, 1'b1, 11'h0, 8'h0);
    tick(1'b1, 1'b1, 11'h100, 8'h00, 1'b0, 1'b1, 11'h0, 8'h0);
    ack_q.delete(); ce_q.delete(); we_cnt = 0;
    tick(1'b0, 1'b1, 11'h000, 8'h00, 1'b0, 1'b1, 11'h0, 8'h0);
    check("t1_cpu_rdata", bus.cpu_rdata, 8'hA5);
    check("t1_ce_cycle5", (ce_q.size() == 1) ? ce_q[0] : -1, 5);

    // Host write then read-back of 0x7FF, request held across the first ack
    ack_q.delete(); we_cnt = 0;
    tick(1'b0, 1'b1, 11'h0, 8'h0, 1'b1, 1'b0, 11'h7FF, 8'h3C);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 11'h0, 8'h0, 1'b1, 1'b1, 11'h7FF, 8'h00);
    tick(1'b0, 1'b1, 11'h0, 8'h0, 1'b0, 1'b1, 11'h000, 8'h00);
    idle_ticks(3);
    check("t2_we_cycles", we_cnt, 1);
    check("t2_we_data", we_data, 8'h3C);
    check("t2_host_rdata", bus.host_rdata, 8'h3C);
    check("t2_ack_count", ack_q.size(), 2);
    if (ack_q.size() == 2) check("t2_ack_gap", ack_q[1] - ack_q[0], 5);

    // WAIT_CYCLES=3 write: four consecutive write-strobe cycles, ce in cycle 8
    check("t4_we_cycles", we3_cnt, 4);
    check("t4_we_first", we3_first, 4);
    check("t4_we_last", we3_last, 7);
    check("t4_ce_count", ce3_q.size(), 1);
    if (ce3_q.size() == 1) check("t4_ce_cycle", ce3_q[0], 8);

    // Both requesting continuously: alternating owners, 10-cycle pulse period
    ack_q.delete(); ce_q.delete();
    for (int i = 0; i < 40; i++)
      tick(1'b1, 1'($urandom_range(0, 1)), 11'($urandom_range(0, 11'h5FF)), 8'($urandom),
           1'b1, 1'($urandom_range(0, 1)), 11'($urandom_range(0, 11'h5FF)), 8'($urandom));
    idle_ticks(4);
    check("t3_ce_count", ce_q.size(), 4);
    check("t3_ack_count", ack_q.size(), 4);
    if (ce_q.size() >= 2) check("t3_ce_period", ce_q[1] - ce_q[0], 10);
    if (ack_q.size() >= 2) check("t3_ack_period", ack_q[1] - ack_q[0], 10);
    if (ce_q.size() >= 1 && ack_q.size() >= 1) check("t3_cpu_first", ack_q[0] - ce_q[0], 5);

    // Host drops its request during ALO: one ack, no re-grant
    ack_q.delete();
    tick(1'b0, 1'b1, 11'h0, 8'h0, 1'b1, 1'b1, 11'($urandom_range(0, 11'h5FF)), 8'h00);
    tick(1'b0, 1'b1, 11'h0, 8'h0, 1'b1, 1'b1, 11'h000, 8'h00);
    tick(1'b0, 1'b1, 11'h0, 8'h0, 1'b0, 1'b1, 11'h000, 8'h00);
    idle_ticks(6);
    check("t6_ack_count", ack_q.size(), 1);

    // Reset during DAT of a host write: no ack, CPU wins first tie afterwards
    tick(1'b0, 1'b1, 11'h0, 8'h0, 1'b1, 1'b0, 11'h600, 8'h99);
    idle_ticks(2);
    next_cycle();
    check("t5_in_dat_we_n", bus.mem_we_n, 1'b0);
    ack_q.delete(); ce_q.delete();
    set_in(1'b1, 1'b1, 11'h020, 8'h00, 1'b1, 1'b1, 11'h030, 8'h00);
    reset_dut();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 11'h020, 8'h00, 1'b1, 1'b1, 11'h030, 8'h00);
    tick(1'b0, 1'b1, 11'h000, 8'h00, 1'b0, 1'b1, 11'h000, 8'h00);
    check("t5_ack_none", ack_q.size(), 0);
    check("t5_ce_count", ce_q.size(), 1);
    if (ce_q.size() == 1) check("t5_ce_cycle", ce_q[0], 5);
    idle_ticks(2);

    // Random traffic against the model
    for (int i = 0; i < 300; i++)
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 11'($urandom_range(0, 11'h5FF)), 8'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 11'($urandom_range(0, 11'h5FF)), 8'($urandom));
    idle_ticks(8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
